uart_tx_core: RTL and testbench

UART transmitter, the TX counterpart of the UART RX back-end. It accepts a parallel byte with a valid strobe and serialises it onto TX_OUT as a frame: start bit, DATA_WIDTH data bits LSB-first, an optional parity bit, then a stop bit. CLK runs at the bit rate, so one CLK cycle equals one bit period; the baud divider lives upstream. The module contains the control FSM, serialiser shift register, bit counter, parity generator and output mux.

---
 rtl/uart_tx_core.sv | 126 ++++++++++++
 tb/tb_uart_tx_core.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_core
// Brief    : UART transmitter. Serialises a latched byte as start bit, data
//            bits LSB-first, optional even/odd parity bit, then stop bit.
//            CLK runs at the bit rate (one cycle per bit).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic                  tx_nxt, busy_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_bit, par_bit_nxt;

  // State, line and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      TX_OUT   <= 1'b1;
      BUSY     <= 1'b0;
      shift    <= '0;
      cnt      <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      state    <= state_nxt;
      TX_OUT   <= tx_nxt;
      BUSY     <= busy_nxt;
      shift    <= shift_nxt;
      cnt      <= cnt_nxt;
      par_en_q <= par_en_nxt;
      par_bit  <= par_bit_nxt;
    end
  end

  // Next-state, next line value and datapath updates; the line value is
  // computed one edge ahead so TX_OUT comes straight from a flop.
  always_comb begin
    state_nxt   = state;
    tx_nxt      = TX_OUT;
    busy_nxt    = BUSY;
    shift_nxt   = shift;
    cnt_nxt     = cnt;
    par_en_nxt  = par_en_q;
    par_bit_nxt = par_bit;

    case (state)
      IDLE, STOP: begin
        if (DATA_VALID) begin
          // Accept: latch the frame configuration and drive the start bit.
          shift_nxt   = P_DATA;
          par_en_nxt  = PAR_EN;
          par_bit_nxt = (^P_DATA) ^ PAR_TYP;
          state_nxt   = START;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
        end else begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
        end
      end

      START: begin
        state_nxt = DATA;
        tx_nxt    = shift[0];
        shift_nxt = shift >> 1;
        cnt_nxt   = '0;
      end

      DATA: begin
        if (cnt == LAST_BIT) begin
          if (par_en_q) begin
            state_nxt = PARITY;
            tx_nxt    = par_bit;
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
        end else begin
          tx_nxt    = shift[0];
          shift_nxt = shift >> 1;
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end

      PARITY: begin
        state_nxt = STOP;
        tx_nxt    = 1'b1;
      end

      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_core
// Brief    : Scoreboard bench for uart_tx_core. The driver decides from the
//            reference model whether a request is accepted and queues the
//            expected line bits; the monitor pops one bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_core;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       BUSY;

  int vectors = 0;
  int errors  = 0;

  // Expected line bits still to appear, one per cycle, while a frame is active.
  bit sb[$];

  uart_tx_core #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference frame: start 0, data LSB-first, optional parity, stop 1.
  function automatic void push_frame(input logic [7:0] d, input bit pe, input bit pt);
    int ones = 0;
    sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      sb.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pe) sb.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    sb.push_back(1'b1);
  endfunction

  // One driver cycle; the model accepts only when no frame bits remain queued
  // (line idle, or the stop bit is the one currently shown).
  task automatic drive(input bit dv, input logic [7:0] d, input bit pe, input bit pt);
    @(negedge CLK);
    #1;
    DATA_VALID = dv;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    if (dv && RST && sb.size() == 0) push_frame(d, pe, pt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle compare the line and BUSY against the scoreboard.
  always @(negedge CLK) begin
    bit exp_tx;
    bit exp_busy;
    if (!RST || sb.size() == 0) begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end else begin
      exp_tx   = sb.pop_front();
      exp_busy = 1'b1;
    end
    vectors++;
    if (TX_OUT !== exp_tx || BUSY !== exp_busy) begin
      errors++;
      $display("FAIL line t=%0t: got tx=%b busy=%b, want tx=%b busy=%b",
               $time, TX_OUT, BUSY, exp_tx, exp_busy);
    end
  end

  initial begin
    // Reset, then idle line.
    idle(3);
    @(negedge CLK); #1; RST = 1'b1;
    idle(20);

    // 0xA5 even parity, odd parity, then 0x01 without parity.
    drive(1'b1, 8'hA5, 1'b1, 1'b0); idle(13);
    drive(1'b1, 8'hA5, 1'b1, 1'b1); idle(13);
    drive(1'b1, 8'h01, 1'b0, 1'b0); idle(12);

    // Back-to-back: request held, data changes during the first stop bit.
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h3C, 1'b0, 1'b0);
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    idle(12);

    // Request during DATA of a 0x00 frame is ignored.
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    idle(3);
    drive(1'b1, 8'hFF, 1'b1, 1'b1);
    idle(12);

    // Asynchronous reset during the 4th data bit of 0x55.
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    idle(4);
    @(posedge CLK); #2;
    RST = 1'b0;
    #1;
    vectors++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got tx=%b busy=%b, want tx=1 busy=0", TX_OUT, BUSY);
    end
    sb.delete();
    idle(2);
    @(negedge CLK); #1; RST = 1'b1;
    drive(1'b1, 8'h0F, 1'b1, 1'b0);
    idle(13);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom), 1'($urandom));
    idle(14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
